// File: rtl/doodle_pkg.sv
// Shared constants and types for the score display path.
package doodle_pkg;

    localparam int SCORE_W = 20;
    localparam int DIGITS  = 6;
    localparam int SR_W    = 4 * DIGITS + SCORE_W;
    localparam logic [SCORE_W-1:0] MAX_SCORE = 20'd999999;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

endpackage

// File: rtl/score_bcd_display_if.sv
// Frame trigger, score input and BCD display outputs of the score converter.
interface score_bcd_display_if;
    import doodle_pkg::*;

    logic                  frame_clk;
    logic [SCORE_W-1:0]    Score;
    logic [4*DIGITS-1:0]   bcd_digits;
    logic [DIGITS-1:0]     blank_mask;
    logic [SCORE_W-1:0]    hi_score;
    logic                  overflow;
    logic                  busy;
    logic                  done;

    modport master (
        output frame_clk, Score,
        input  bcd_digits, blank_mask, hi_score, overflow, busy, done
    );

    modport slave (
        input  frame_clk, Score,
        output bcd_digits, blank_mask, hi_score, overflow, busy, done
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more.
module bcd_add3
    import doodle_pkg::*;
(
    input  bcd_t d,
    output bcd_t q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/score_bcd_display.sv
// Once per frame, clamps Score and converts it to six BCD digits with a
// sequential double-dabble; also tracks the high score and leading-zero blanking.
module score_bcd_display
    import doodle_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    score_bcd_display_if.slave  bus
);

    localparam logic [4:0] LAST_ITER = 5'(SCORE_W - 1);

    logic                 sync_meta, sync_q, sync_qq;
    logic                 fc_rise;
    bcd_state_t           state;
    logic [4:0]           iter;
    logic [SR_W-1:0]      sr;
    logic [SR_W-1:0]      sr_next;
    logic [4*DIGITS-1:0]  bcd_corr;
    logic [SCORE_W-1:0]   cap;

    logic [4*DIGITS-1:0]  bcd_q;
    logic [DIGITS-1:0]    mask_q;
    logic [SCORE_W-1:0]   hi_q;
    logic                 ovf_q, busy_q, done_q;

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
        return (s > MAX_SCORE) ? MAX_SCORE : s;
    endfunction

    // Bit i is set when digit i and every more significant digit are zero.
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] m;
        logic              all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (d[4*i +: 4] == 4'd0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

    assign fc_rise = sync_q & ~sync_qq;
    assign cap     = sat_score(bus.Score);

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (sr[SCORE_W + 4*g +: 4]),
            .q (bcd_corr[4*g +: 4])
        );
    end

    assign sr_next = {bcd_corr, sr[SCORE_W-1:0]} << 1;

    // Shift register is pure datapath; it is always reloaded before use.
    always_ff @(posedge Clk) begin
        if (state == IDLE && fc_rise)
            sr <= {{(4*DIGITS){1'b0}}, cap};
        else if (state == SHIFT)
            sr <= sr_next;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_qq   <= 1'b0;
            state     <= IDLE;
            iter      <= '0;
            bcd_q     <= '0;
            mask_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
            hi_q      <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync_meta <= bus.frame_clk;
            sync_q    <= sync_meta;
            sync_qq   <= sync_q;
            done_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fc_rise) begin
                        ovf_q  <= (bus.Score > MAX_SCORE);
                        if (cap > hi_q)
                            hi_q <= cap;
                        iter   <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    iter <= iter + 5'd1;
                    if (iter == LAST_ITER)
                        state <= DONE;
                end
                DONE: begin
                    bcd_q  <= sr[SR_W-1 -: 4*DIGITS];
                    mask_q <= lead_zero_mask(sr[SR_W-1 -: 4*DIGITS]);
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bcd_digits = bcd_q;
    assign bus.blank_mask = mask_q;
    assign bus.hi_score   = hi_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Randomised self-checking bench for score_bcd_display against a decimal-arithmetic model.
module tb_score_bcd_display;
    import doodle_pkg::*;

    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_bad;
    int   model_hi;

    score_bcd_display_if bus();

    score_bcd_display dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int s);
        return (s > 999999) ? 999999 : s;
    endfunction

    function automatic logic [31:0] exp_bcd(input int v);
        logic [31:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int d = 0; d < 6; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_mask(input int v);
        logic [31:0] m;
        int          p;
        m = '0;
        p = 10;
        for (int i = 1; i < 6; i++) begin
            m[i] = (v < p);
            p = p * 10;
        end
        return m;
    endfunction

    task automatic check_results(input string tag, input int s);
        int c;
        c = clamp(s);
        if (c > model_hi) model_hi = c;
        check({tag, ".digits"}, 32'(bus.bcd_digits), exp_bcd(c));
        check({tag, ".mask"},   32'(bus.blank_mask), exp_mask(c));
        check({tag, ".hi"},     32'(bus.hi_score),   32'(model_hi));
        check({tag, ".ovf"},    32'(bus.overflow),   32'(s > 999999));
        check({tag, ".busy"},   32'(bus.busy),       32'd0);
    endtask

    task automatic idle_frame_low();
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
    endtask

    // One frame: conversion result, latency from frame_clk rise, single-cycle done.
    task automatic run_frame(input string tag, input int s);
        int  cyc;
        bit  got;
        @(negedge Clk);
        bus.Score     = 20'(s);
        bus.frame_clk = 1'b1;
        cyc = 0;
        got = 0;
        while (cyc < 60 && !got) begin
            @(posedge Clk);
            cyc++;
            #1;
            if (cyc == 12) bus.Score = 20'($urandom);
            if (bus.done) got = 1;
        end
        check({tag, ".latency"}, 32'(cyc), 32'd24);
        check_results(tag, s);
        @(posedge Clk);
        #1;
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        idle_frame_low();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".digits"}, 32'(bus.bcd_digits), 32'h0);
        check({tag, ".mask"},   32'(bus.blank_mask), 32'b111110);
        check({tag, ".hi"},     32'(bus.hi_score),   32'd0);
        check({tag, ".ovf"},    32'(bus.overflow),   32'd0);
        check({tag, ".busy"},   32'(bus.busy),       32'd0);
        check({tag, ".done"},   32'(bus.done),       32'd0);
    endtask

    initial begin
        int dones;
        int first_lat;
        int v;
        logic [31:0] first_digits;

        n_cmp         = 0;
        n_bad         = 0;
        model_hi      = 0;
        Reset         = 1'b1;
        bus.frame_clk = 1'b0;
        bus.Score     = '0;
        repeat (3) @(negedge Clk);
        check_reset_values("reset");
        Reset = 1'b0;
        repeat (3) @(negedge Clk);

        run_frame("zero", 0);
        run_frame("six_digit", 123456);
        run_frame("small", 42);
        run_frame("smaller", 7);
        run_frame("overflow", 20'hFFFFF);
        run_frame("max", 999999);

        // Retrigger 5 cycles into the conversion is dropped.
        @(negedge Clk);
        bus.Score     = 20'd314159;
        bus.frame_clk = 1'b1;
        dones = 0;
        first_lat = 0;
        first_digits = '0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge Clk);
            #1;
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    first_lat    = c;
                    first_digits = 32'(bus.bcd_digits);
                end
            end
            if (c == 6)  bus.frame_clk = 1'b0;
            if (c == 8) begin
                bus.frame_clk = 1'b1;
                bus.Score     = 20'd271828;
            end
        end
        check("retrig.count",   32'(dones), 32'd1);
        check("retrig.latency", 32'(first_lat), 32'd24);
        check("retrig.digits",  first_digits, exp_bcd(314159));
        idle_frame_low();

        // Reset during iteration 10 aborts the conversion.
        @(negedge Clk);
        bus.Score     = 20'd888888;
        bus.frame_clk = 1'b1;
        repeat (13) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge Clk);
        check_reset_values("midreset_hold");
        Reset         = 1'b0;
        bus.frame_clk = 1'b0;
        model_hi      = 0;
        repeat (4) @(negedge Clk);
        run_frame("after_reset", 500);

        for (int k = 0; k < 20; k++) begin
            case (k % 4)
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(0, 20'hFFFFF));
                2:       v = int'($urandom_range(999990, 1000010));
                default: v = int'($urandom_range(0, 999999));
            endcase
            run_frame("rand", v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
